// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache responder.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        inval,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {COMPARE, FETCH} state_t;

    state_t             state, state_n;
    logic [31:0]        miss_addr, miss_addr_n;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags [SETS];
    logic [31:0]        data [SETS];

    logic [IDX_W-1:0]   req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               lookup_hit, fill, miss_start;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr[IDX_W+1:2];
    assign fill_tag = miss_addr[31:IDX_W+2];

    assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

    always_comb begin
        state_n     = state;
        miss_addr_n = miss_addr;
        ihit        = 1'b0;
        imemload    = 32'h0;
        iREN        = 1'b0;
        iaddr       = 32'h0;
        fill        = 1'b0;
        miss_start  = 1'b0;
        unique case (state)
            COMPARE: begin
                if (imemREN && lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = data[req_idx];
                end else if (imemREN) begin
                    miss_start  = 1'b1;
                    miss_addr_n = {imemaddr[31:2], 2'b00};
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill    = 1'b1;
                    state_n = COMPARE;
                end
            end
            default: state_n = COMPARE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= COMPARE;
            miss_addr <= 32'h0;
        end else begin
            state     <= state_n;
            miss_addr <= miss_addr_n;
        end
    end

    // Invalidate wins over a fill landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST || inval) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && fill) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit && hit_count != 32'hFFFF_FFFF)
                hit_count <= hit_count + 32'h1;
            if (miss_start && miss_count != 32'hFFFF_FFFF)
                miss_count <= miss_count + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder.
// Counter checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_responder;
    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        inval;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    icache_responder #(.SETS(16)) dut (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN), .imemaddr(imemaddr), .inval(inval),
        .ihit(ihit), .imemload(imemload),
        .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // From COMPARE with a miss pending on addr: fetch then fill with d.
    task automatic fill(input logic [31:0] addr, input logic [31:0] d,
                        input int waits);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        tick();
        for (int i = 0; i < waits; i++) tick();
        iwait = 1'b0;
        iload = d;
        tick();
        iwait = 1'b1;
        iload = 32'h0;
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0;
        inval = 1'b0; iwait = 1'b1; iload = 32'h0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_ihit", {31'h0, ihit}, 32'h0);
        chk("rst_load", imemload, 32'h0);
        chk("rst_iren", {31'h0, iREN}, 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);

        // cold miss
        imemREN = 1'b1; imemaddr = 32'h0;
        #1;
        chk("cold_comb_ihit", {31'h0, ihit}, 32'h0);
        tick();
        chk("cold_iren", {31'h0, iREN}, 32'h1);
        chk("cold_iaddr", iaddr, 32'h0);
        chk("cold_fetch_ihit", {31'h0, ihit}, 32'h0);
        tick();
        chk("cold_wait2_iren", {31'h0, iREN}, 32'h1);
        iwait = 1'b0; iload = 32'h2402_0001;
        tick();
        iwait = 1'b1; iload = 32'h0;
        chk("cold_hit", {31'h0, ihit}, 32'h1);
        chk("cold_load", imemload, 32'h2402_0001);
        chk("cold_iren_low", {31'h0, iREN}, 32'h0);

        // imemREN low: no hit, no fetch
        imemREN = 1'b0;
        #1;
        chk("ren0_ihit", {31'h0, ihit}, 32'h0);
        chk("ren0_load", imemload, 32'h0);
        tick();
        chk("ren0_iren", {31'h0, iREN}, 32'h0);

        // conflict on frame 0
        imemREN = 1'b1; imemaddr = 32'h40;
        #1;
        chk("conf_miss", {31'h0, ihit}, 32'h0);
        tick();
        chk("conf_iaddr", iaddr, 32'h40);
        iwait = 1'b0; iload = 32'h1111_1111;
        tick();
        iwait = 1'b1;
        chk("conf_hit40", imemload, 32'h1111_1111);
        imemaddr = 32'h0;
        #1;
        chk("conf_remiss0", {31'h0, ihit}, 32'h0);
        tick();
        chk("conf_iaddr0", iaddr, 32'h0);
        iwait = 1'b0; iload = 32'h2402_0001;
        tick();
        iwait = 1'b1;
        chk("conf_rehit0", imemload, 32'h2402_0001);

        // redirect during fetch
        imemaddr = 32'h8;
        tick();
        imemaddr = 32'hC;
        #1;
        chk("redir_iaddr", iaddr, 32'h8);
        chk("redir_ihit", {31'h0, ihit}, 32'h0);
        tick();
        chk("redir_iaddr_hold", iaddr, 32'h8);
        iwait = 1'b0; iload = 32'hAAAA_0008;
        tick();
        iwait = 1'b1;
        chk("redir_c_miss", {31'h0, ihit}, 32'h0);
        tick();
        chk("redir_c_iaddr", iaddr, 32'hC);
        iwait = 1'b0; iload = 32'hCCCC_000C;
        tick();
        iwait = 1'b1;
        chk("redir_c_hit", imemload, 32'hCCCC_000C);
        imemaddr = 32'h8;
        #1;
        chk("redir_8_hit", imemload, 32'hAAAA_0008);

        // invalidate while hitting
        imemaddr = 32'h0; inval = 1'b1;
        #1;
        chk("inval_same_cycle_hit", {31'h0, ihit}, 32'h1);
        tick();
        inval = 1'b0;
        chk("inval_next_miss", {31'h0, ihit}, 32'h0);
        tick();
        chk("inval_iren", {31'h0, iREN}, 32'h1);
        chk("inval_iaddr", iaddr, 32'h0);
        // inval coincident with fill completion
        iwait = 1'b0; iload = 32'h2402_0001; inval = 1'b1;
        tick();
        iwait = 1'b1; inval = 1'b0;
        chk("inval_fill_invalid", {31'h0, ihit}, 32'h0);
        tick();
        chk("inval_refetch", {31'h0, iREN}, 32'h1);
        iwait = 1'b0;
        tick();
        iwait = 1'b1;
        chk("inval_refill_hit", imemload, 32'h2402_0001);

        // reset mid-fetch
        imemaddr = 32'h4;
        tick();
        chk("rstf_iren_before", {31'h0, iREN}, 32'h1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        imemREN = 1'b1;
        chk("rstf_iren", {31'h0, iREN}, 32'h0);
        chk("rstf_iaddr", iaddr, 32'h0);
        imemaddr = 32'h0;  #1; chk("rstf_miss0", {31'h0, ihit}, 32'h0);
        imemaddr = 32'h8;  #1; chk("rstf_miss8", {31'h0, ihit}, 32'h0);
        imemaddr = 32'hC;  #1; chk("rstf_missC", {31'h0, ihit}, 32'h0);
        imemaddr = 32'h40; #1; chk("rstf_miss40", {31'h0, ihit}, 32'h0);

`ifdef ICACHE_STATS_EN
        chk("st_hit_rst", hit_count, 32'h0);
        chk("st_miss_rst", miss_count, 32'h0);
        fill(32'h0, 32'h2402_0001, 0);
        tick();
        tick();
        tick();
        chk("st_hit3", hit_count, 32'h3);
        chk("st_miss1", miss_count, 32'h1);
        fill(32'h4, 32'h2403_0002, 1);
        chk("st_hit_after4", hit_count, 32'h3);
        chk("st_miss2", miss_count, 32'h2);
        tick();
        chk("st_hit4", hit_count, 32'h4);
        inval = 1'b1;
        tick();
        inval = 1'b0;
        chk("st_inval_keep", miss_count, 32'h2);
`else
        fill(32'h0, 32'h2402_0001, 0);
        chk("fill_task_hit", imemload, 32'h2402_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
